// File: rtl/bsr_call_stack.sv
// bsr_call_stack: branch-to-subroutine / return unit for the EV20 sequencer.
// A branch emits OLD_PC + ext(S) and pushes OLD_PC onto a DEPTH-entry LIFO;
// a return pops the top entry and emits top + 1. Storage is a shift chain
// with entry 0 as the top of stack, so the oldest entry falls off the end
// when a wrapping push hits a full stack.
module bsr_call_stack #(
   parameter int PC_W       = 11,
   parameter int OFS_W      = 10,
   parameter int OFS_SIGNED = 0,
   parameter int DEPTH      = 4,
   parameter int OVF_WRAP   = 1,
   localparam int LVL_W     = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             branch,
   input  logic             ret,
   input  logic             err_clr,
   input  logic [OFS_W-1:0] S,
   input  logic [PC_W-1:0]  OLD_PC,
   output logic [PC_W-1:0]  NEW_PC,
   output logic             pc_valid,
   output logic [LVL_W-1:0] level,
   output logic             full,
   output logic             empty,
   output logic             err_ovf,
   output logic             err_udf
);

   logic [PC_W-1:0] stack [DEPTH];
   logic [PC_W-1:0] ofs_ext;
   logic            push_ok;

   // Extend the branch offset to PC width, zero- or sign-filling the upper bits.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      ofs_ext = '0;
      ofs_ext[OFS_W-1:0] = S;
      for (int i = OFS_W; i < PC_W; i++) begin
         ofs_ext[i] = (OFS_SIGNED != 0) && S[OFS_W-1];
      end
   end

   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == '0);
   // A push proceeds unless the stack is full and the policy rejects it.
   assign push_ok = !full || (OVF_WRAP != 0);

   // Request handling: branch beats ret; errors are sticky until err_clr.
   always_ff @(posedge clk) begin
      if (rst) begin
         NEW_PC   <= '0;
         pc_valid <= 1'b0;
         level    <= '0;
         err_ovf  <= 1'b0;
         err_udf  <= 1'b0;
         // NOTE: the stack entries are architecturally zero after reset, so the array is reset too.
         for (int i = 0; i < DEPTH; i++) begin
            stack[i] <= '0;
         end
      end else begin
         // NOTE: all state here uses non-blocking assignments so every entry shifts from its pre-edge value.
         pc_valid <= 1'b0;
         // Clear first; an error raised below in the same cycle overrides it.
         if (err_clr) begin
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
         end
         if (enable) begin
            if (branch) begin
               if (full) begin
                  err_ovf <= 1'b1;
               end
               if (push_ok) begin
                  NEW_PC   <= OLD_PC + ofs_ext;
                  pc_valid <= 1'b1;
                  for (int i = DEPTH - 1; i > 0; i--) begin
                     stack[i] <= stack[i-1];
                  end
                  stack[0] <= OLD_PC;
                  if (!full) begin
                     level <= level + LVL_W'(1);
                  end
               end
            end else if (ret) begin
               if (empty) begin
                  err_udf <= 1'b1;
               end else begin
                  NEW_PC   <= stack[0] + PC_W'(1);
                  pc_valid <= 1'b1;
                  for (int i = 0; i < DEPTH - 1; i++) begin
                     stack[i] <= stack[i+1];
                  end
                  stack[DEPTH-1] <= '0;
                  level <= level - LVL_W'(1);
               end
            end
         end
      end
   end

endmodule
